tail_light_scheduler: RTL and testbench
=======================================

// Module: tail_light_scheduler
// PURPOSE
//  Mode scheduler for the six-lamp tail-light datapath on the EGO1 board.
//  - Synchronises and debounces the mode switches.
//  - Arbitrates between left, right, hazard and (optional) brake requests.
//  - Sequences the lamp patterns from a divided step tick.
//  - Sits between sw_pin and led_pin as the single owner of the lamp outputs.
// PARAMETERS
//  TICK_CYCLES  33554432  clk cycles per pattern step (tick period)
//  DEB_CYCLES   1000000   consecutive stable samples required to accept a switch change
// PORTS
//  sys_clk_in  in   1   system clock
//  sys_rst_n   in   1   reset, asynchronous, active-low
//  sw_pin      in   8   [0]=left req, [1]=right req, [2]=hazard req, [3]=brake, [7:4] ignored
//  led_pin     out  16  [2:0] left lamps, [7:5] right lamps, [15:12] mode one-hot, others 0
// BEHAVIOUR
//  - Reset (async): clears all state immediately.
//    - led_pin=16'h0000, state=IDLE, step=0.
//    - Tick counter = 0; synchroniser and debounced switches = 0.
//  - Input path: 2-flop synchroniser per sw_pin[3:0], then per-bit debounce counter.
//    - Debounced value updates only after DEB_CYCLES consecutive identical synced samples.
//    - Any mismatch restarts that bit's count.
//  - Arbitration on debounced bits, evaluated every cycle (priority high to low):
//    - HAZARD if hz=1 or (left=1 and right=1).
//    - LEFT if left only; RIGHT if right only; otherwise IDLE.
//  - FSM states: IDLE, LEFT, RIGHT, HAZARD.
//    - On a state change: step=0 and tick counter=0, so the new pattern starts at step 0 with a full period.
//  - Tick: counter runs 0..TICK_CYCLES-1 and wraps; tick is a 1-cycle pulse at the wrap.
//  - Step: advances on tick only.
//    - LEFT/RIGHT: step 0->1->2->0.
//    - HAZARD: phase 0->1->0.
//    - IDLE: step held at 0.
//  - Patterns (lamp bits not listed are 0):
//    - IDLE: all six lamps off.
//    - LEFT: step0 led[2], step1 led[1], step2 led[0].
//    - RIGHT: step0 led[5], step1 led[6], step2 led[7].
//    - HAZARD: phase0 all off, phase1 led[2:0]=111 and led[7:5]=111.
//  - led_pin[15:12] mode indicator: IDLE=0001, LEFT=0010, RIGHT=0100, HAZARD=1000.
//  - Output timing:
//    - led_pin is fully registered; it reflects state/step one cycle after they change.
//    - sw change to led_pin change = 2 (sync) + DEB_CYCLES + 2 cycles.
//  - Boundary conditions:
//    - Tick coinciding with a state change: the state change wins; step=0 and counter=0.
//    - Switch toggling faster than DEB_CYCLES: no state change.
//    - Reset mid-pattern: outputs clear asynchronously; after release the block resumes in IDLE.
// CONFIGURATION
//  - BRAKE_EN defined: debounced sw_pin[3] overlays the pattern.
//    - IDLE + brake: all six lamps on steady.
//    - LEFT + brake: led[7:5]=111 steady, led[2:0] keep sequencing.
//    - RIGHT + brake: led[2:0]=111 steady, led[7:5] keep sequencing.
//    - HAZARD: brake ignored.
//    - Brake does not change state or reset step/tick.
//  - BRAKE_EN undefined: sw_pin[3] is ignored and no brake logic is synthesised.
// TESTING (bench uses TICK_CYCLES=8, DEB_CYCLES=4)
//  1. Hold sys_rst_n=0 -> led_pin=16'h0000; release with sw=0 -> led_pin=16'h1000 within 2 cycles.
//  2. sw_pin=8'h01 -> led_pin=16'h2004 after 8 cycles, then 16'h2002, 16'h2001, 16'h2004 every 8 cycles.
//  3. sw_pin=8'h03 -> led_pin=16'h8000, then 16'h80E7, alternating every 8 cycles.
//  4. Pulse sw_pin[1]=1 for 3 cycles only -> led_pin stays 16'h1000.
//  5. BRAKE_EN, sw_pin=8'h08 -> 16'h10E7; then sw_pin=8'h09 -> right lamps steady 111, left lamps sequencing.
//  6. sys_rst_n=0 mid-HAZARD phase1 -> led_pin=16'h0000 in the same cycle (asynchronous clear).

Source files
------------

// File: rtl/tail_light_scheduler.sv
// Tail-light mode scheduler: synchronise/debounce switches, arbitrate mode, sequence lamps.
// Optional brake overlay on sw_pin[3] is built only when BRAKE_EN is defined.
module tail_light_scheduler #(
    parameter int unsigned TICK_CYCLES = 33554432,
    parameter int unsigned DEB_CYCLES  = 1000000
) (
    input  logic        sys_clk_in,
    input  logic        sys_rst_n,
    input  logic [7:0]  sw_pin,
    output logic [15:0] led_pin
);

`ifdef BRAKE_EN
    localparam int NSW = 4;
`else
    localparam int NSW = 3;
`endif

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int DW = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LEFT   = 2'd1;
    localparam logic [1:0] ST_RIGHT  = 2'd2;
    localparam logic [1:0] ST_HAZARD = 2'd3;

    logic [NSW-1:0]         sync1_q, sync2_q;
    logic [NSW-1:0]         deb_q, deb_d;
    logic [NSW-1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]             state_q, state_d;
    logic [1:0]             step_q, step_d;
    logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
    logic [15:0]            led_d;
    logic                   tick;
    logic                   state_chg;
    logic                   left_req, right_req, hazard_req;

`ifdef BRAKE_EN
    logic unused_sw;
    assign unused_sw = ^sw_pin[7:4];
`else
    logic unused_sw;
    assign unused_sw = ^sw_pin[7:3];
`endif

    // A mismatching sample bumps the bit's count; a matching one clears it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        deb_d     = deb_q;
        deb_cnt_d = '0;
        for (int b = 0; b < NSW; b++) begin
            if (sync2_q[b] != deb_q[b]) begin
                if (deb_cnt_q[b] == DW'(DEB_CYCLES - 1)) begin
                    deb_d[b] = sync2_q[b];
                end else begin
                    deb_cnt_d[b] = deb_cnt_q[b] + 1'b1;
                end
            end
        end
    end

    assign left_req   = deb_q[0];
    assign right_req  = deb_q[1];
    assign hazard_req = deb_q[2];

    always_comb begin
        state_d = ST_IDLE;
        if (hazard_req || (left_req && right_req)) begin
            state_d = ST_HAZARD;
        end else if (left_req) begin
            state_d = ST_LEFT;
        end else if (right_req) begin
            state_d = ST_RIGHT;
        end
    end

    assign state_chg = (state_d != state_q);
    assign tick      = (tick_cnt_q == TW'(TICK_CYCLES - 1));

    // A state change outranks a coincident tick: the new pattern restarts cleanly.
    always_comb begin
        tick_cnt_d = tick_cnt_q + 1'b1;
        step_d     = step_q;
        if (state_chg) begin
            tick_cnt_d = '0;
            step_d     = 2'd0;
        end else if (tick) begin
            tick_cnt_d = '0;
            case (state_q)
                ST_LEFT, ST_RIGHT: step_d = (step_q == 2'd2) ? 2'd0 : step_q + 2'd1;
                ST_HAZARD:         step_d = (step_q == 2'd0) ? 2'd1 : 2'd0;
                default:           step_d = 2'd0;
            endcase
        end
    end

    always_comb begin
        logic [3:0] mode;
        logic [2:0] left_lamps;
        logic [2:0] right_lamps;
        mode        = 4'b0001;
        left_lamps  = 3'b000;
        right_lamps = 3'b000;
        case (state_q)
            ST_LEFT: begin
                mode = 4'b0010;
                case (step_q)
                    2'd0:    left_lamps = 3'b100;
                    2'd1:    left_lamps = 3'b010;
                    2'd2:    left_lamps = 3'b001;
                    default: left_lamps = 3'b000;
                endcase
            end
            ST_RIGHT: begin
                mode = 4'b0100;
                case (step_q)
                    2'd0:    right_lamps = 3'b001;
                    2'd1:    right_lamps = 3'b010;
                    2'd2:    right_lamps = 3'b100;
                    default: right_lamps = 3'b000;
                endcase
            end
            ST_HAZARD: begin
                mode = 4'b1000;
                if (step_q == 2'd1) begin
                    left_lamps  = 3'b111;
                    right_lamps = 3'b111;
                end
            end
            default: mode = 4'b0001;
        endcase
`ifdef BRAKE_EN
        // Brake lights whichever side is not signalling; hazard ignores it.
        if (deb_q[3]) begin
            case (state_q)
                ST_IDLE: begin
                    left_lamps  = 3'b111;
                    right_lamps = 3'b111;
                end
                ST_LEFT:  right_lamps = 3'b111;
                ST_RIGHT: left_lamps  = 3'b111;
                default:  ;
            endcase
        end
`endif
        led_d = {mode, 4'b0000, right_lamps, 2'b00, left_lamps};
    end

    always_ff @(posedge sys_clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            step_q     <= 2'd0;
            tick_cnt_q <= '0;
            led_pin    <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            sync1_q    <= sw_pin[NSW-1:0];
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_cnt_q  <= deb_cnt_d;
            state_q    <= state_d;
            step_q     <= step_d;
            tick_cnt_q <= tick_cnt_d;
            led_pin    <= led_d;
        end
    end

endmodule

// File: tb/tb_tail_light_scheduler.sv
// Directed bench for tail_light_scheduler with TICK_CYCLES=8, DEB_CYCLES=4.
// Define BRAKE_EN for both files to exercise the brake overlay.
module tb_tail_light_scheduler;

    logic        clk;
    logic        rst_n;
    logic [7:0]  sw;
    logic [15:0] led;
    int          checks;
    int          errors;

    tail_light_scheduler #(
        .TICK_CYCLES(8),
        .DEB_CYCLES (4)
    ) dut (
        .sys_clk_in(clk),
        .sys_rst_n (rst_n),
        .sw_pin    (sw),
        .led_pin   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_reset();
        sw    = 8'h00;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        sw    = 8'h00;
        rst_n = 1'b0;
        step(3);
        checks++;
        if (led !== 16'h0000) begin
            errors++;
            $display("FAIL reset_hold got %h exp %h", led, 16'h0000);
        end
        rst_n = 1'b1;
        step(1);
        checks++;
        if (led !== 16'h1000) begin
            errors++;
            $display("FAIL reset_release got %h exp %h", led, 16'h1000);
        end
    endtask

    task automatic test_left();
        logic [15:0] exp_seq [4] = '{16'h2004, 16'h2002, 16'h2001, 16'h2004};
        apply_reset();
        sw = 8'h01;
        step(7);
        checks++;
        if (led !== 16'h1000) begin
            errors++;
            $display("FAIL left_latency got %h exp %h", led, 16'h1000);
        end
        step(1);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(8);
            checks++;
            if (led !== exp_seq[i]) begin
                errors++;
                $display("FAIL left_step%0d got %h exp %h", i, led, exp_seq[i]);
            end
        end
    endtask

    // Entered right after LEFT step0 appears, so the state change lands on the tick edge.
    task automatic test_back_to_back();
        sw = 8'h03;
        step(7);
        checks++;
        if (led !== 16'h2004) begin
            errors++;
            $display("FAIL b2b_before got %h exp %h", led, 16'h2004);
        end
        step(1);
        checks++;
        if (led !== 16'h8000) begin
            errors++;
            $display("FAIL b2b_tick_collide got %h exp %h", led, 16'h8000);
        end
        step(7);
        checks++;
        if (led !== 16'h8000) begin
            errors++;
            $display("FAIL b2b_full_period got %h exp %h", led, 16'h8000);
        end
        step(1);
        checks++;
        if (led !== 16'h80E7) begin
            errors++;
            $display("FAIL b2b_phase1 got %h exp %h", led, 16'h80E7);
        end
    endtask

    task automatic test_hazard();
        apply_reset();
        sw = 8'h03;
        step(7);
        checks++;
        if (led !== 16'h1000) begin
            errors++;
            $display("FAIL hazard_latency got %h exp %h", led, 16'h1000);
        end
        step(1);
        checks++;
        if (led !== 16'h8000) begin
            errors++;
            $display("FAIL hazard_phase0 got %h exp %h", led, 16'h8000);
        end
        step(8);
        checks++;
        if (led !== 16'h80E7) begin
            errors++;
            $display("FAIL hazard_phase1 got %h exp %h", led, 16'h80E7);
        end
        step(8);
        checks++;
        if (led !== 16'h8000) begin
            errors++;
            $display("FAIL hazard_phase0b got %h exp %h", led, 16'h8000);
        end
        step(8);
    endtask

    task automatic test_async_reset();
        step(2);
        checks++;
        if (led !== 16'h80E7) begin
            errors++;
            $display("FAIL async_pre got %h exp %h", led, 16'h80E7);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (led !== 16'h0000) begin
            errors++;
            $display("FAIL async_clear got %h exp %h", led, 16'h0000);
        end
        step(2);
        rst_n = 1'b1;
        step(1);
        checks++;
        if (led !== 16'h1000) begin
            errors++;
            $display("FAIL async_resume_idle got %h exp %h", led, 16'h1000);
        end
        step(7);
        checks++;
        if (led !== 16'h8000) begin
            errors++;
            $display("FAIL async_rearm got %h exp %h", led, 16'h8000);
        end
    endtask

    task automatic test_right();
        logic [15:0] exp_seq [4] = '{16'h4020, 16'h4040, 16'h4080, 16'h4020};
        apply_reset();
        sw = 8'h02;
        step(8);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step(8);
            checks++;
            if (led !== exp_seq[i]) begin
                errors++;
                $display("FAIL right_step%0d got %h exp %h", i, led, exp_seq[i]);
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        sw = 8'h02;
        step(3);
        sw = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step(4);
            checks++;
            if (led !== 16'h1000) begin
                errors++;
                $display("FAIL glitch_%0d got %h exp %h", i, led, 16'h1000);
            end
        end
    endtask

`ifdef BRAKE_EN
    task automatic test_brake();
        logic [15:0] exp_seq [3] = '{16'h20E4, 16'h20E2, 16'h20E1};
        apply_reset();
        sw = 8'h08;
        step(7);
        checks++;
        if (led !== 16'h1000) begin
            errors++;
            $display("FAIL brake_latency got %h exp %h", led, 16'h1000);
        end
        step(1);
        checks++;
        if (led !== 16'h10E7) begin
            errors++;
            $display("FAIL brake_idle got %h exp %h", led, 16'h10E7);
        end
        sw = 8'h09;
        step(8);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step(8);
            checks++;
            if (led !== exp_seq[i]) begin
                errors++;
                $display("FAIL brake_left%0d got %h exp %h", i, led, exp_seq[i]);
            end
        end
    endtask
`else
    task automatic test_ignored_bits();
        apply_reset();
        sw = 8'hF8;
        for (int i = 0; i < 3; i++) begin
            step(5);
            checks++;
            if (led !== 16'h1000) begin
                errors++;
                $display("FAIL ignored_bits_%0d got %h exp %h", i, led, 16'h1000);
            end
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        sw     = 8'h00;
        test_reset();
        test_left();
        test_back_to_back();
        test_hazard();
        test_async_reset();
        test_right();
        test_glitch();
`ifdef BRAKE_EN
        test_brake();
`else
        test_ignored_bits();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
